status_seg7_panel: RTL and testbench
====================================

Name: status_seg7_panel

Overview:
Parametrised successor to the three-digit pipeline status display (stall / exception / PC-invalid). Drives NUM_CH active-low 7-segment digits, one per status event. Each digit shows a configurable glyph. A per-channel FSM supports three modes: live pass-through, pulse stretching (so single-cycle events are visible), and sticky latching with optional blink. The block sits at board top level between the CPU status outputs and the HEX pins.

Parameters:
NUM_CH, 3, number of status channels/digits (1..8)
GLYPHS, {7'b1000001,7'b0000110,7'b0010010}, packed glyphs; channel i uses bits [7i+6:7i]; default ch0 S, ch1 E, ch2 U
HOLD_CYCLES, 50000000, cycles a stretched event stays visible after its input falls (>=1)
BLINK_DIV, 25000000, cycles per blink half-period (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
event_in  in  NUM_CH  status events, bit i = channel i, sampled every edge
mode  in  2  00 LIVE, 01 STRETCH, 10 STICKY, 11 treated as LIVE
clear_all  in  1  drops all HOLD/LATCHED channels to IDLE
blink_en  in  1  enables blinking of LATCHED channels
lamp_test  in  1  forces all segments on
seg_out  out  7*NUM_CH  active-low segments {g,f,e,d,c,b,a}, digit i at [7i+6:7i]
status_any  out  1  high when any channel is not IDLE

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). All state updates on the rising edge of clk.
- Reset: every seg_out digit = 7'b1111111 (blank); status_any=0; all channels IDLE; hold counters 0; blink counter 0; blink phase=1 (visible).
- Outputs are registered and driven from next-state: an event sampled high at edge k shows its glyph from edge k (1-cycle latency from input change).
- Channel FSM, states IDLE, ACTIVE, HOLD, LATCHED. Priority: rst > event_in > clear_all > mode/counter.
  - IDLE: event -> ACTIVE; else stay.
  - ACTIVE: event -> stay. On no event: LIVE -> IDLE; STRETCH -> HOLD with cnt=HOLD_CYCLES-1; STICKY -> LATCHED.
  - HOLD: event -> ACTIVE. Else clear_all -> IDLE. Else mode!=STRETCH -> IDLE. Else cnt==0 -> IDLE. Else cnt-1.
  - LATCHED: event -> ACTIVE. Else clear_all -> IDLE. Else mode!=STICKY -> IDLE. Else stay.
- Simultaneous event and clear_all on a channel: the event wins (ACTIVE).
- Hold counter width is $clog2(HOLD_CYCLES+1). It never underflows. An event during HOLD re-arms a full HOLD_CYCLES on the next fall.
- Blink prescaler: shared counter 0..BLINK_DIV-1. At wrap it resets to 0 and toggles the phase. It runs continuously from reset.
- Digit value:
  - lamp_test=1 -> 7'b0000000.
  - IDLE -> blank.
  - ACTIVE or HOLD -> glyph.
  - LATCHED -> glyph if (!blink_en or phase) else blank.
- status_any is registered as the OR of next-state != IDLE over all channels.
- Mode changes take effect at the next edge; no glitch digits are produced.

Decomposition:
- Package status_seg7_pkg:
  - glyph constants BLANK, ALL_ON, digits 0-9, S/E/U
  - mode encoding (MODE_LIVE, MODE_STRETCH, MODE_STICKY)
  - channel state enum
- Sub-module status_seg7_chan: one channel's FSM, hold counter and glyph mux, instantiated NUM_CH times via generate. Inputs are the blink phase, mode, clear_all, lamp_test and that channel's GLYPHS slice.
- The top level holds the blink prescaler and the status_any reduction.

Test Plan:
- Bench parameters: NUM_CH=3, HOLD_CYCLES=4, BLINK_DIV=2. Default GLYPHS.
- rst=1 for 2 cycles with event_in=3'b111 -> seg_out all 7'b1111111, status_any=0. Release -> glyphs appear one edge later.
- LIVE, event_in=3'b001 for 1 cycle at edge k -> digit0=7'b0010010 from edge k, blank at k+1; digits 1/2 blank throughout.
- STRETCH, event_in[1] pulsed at edge k -> digit1=7'b0000110 on edges k..k+4, blank at k+5. A second pulse at k+3 extends visibility to k+3+5.
- STICKY, blink_en=1, pulse event_in[2] -> digit2 alternates 7'b1000001 / blank every 2 cycles. clear_all=1 -> blank next edge and status_any=0.
- STICKY, channel 0 LATCHED, clear_all and event_in[0] asserted together -> ACTIVE, solid 7'b0010010. Then lamp_test=1 -> all digits 7'b0000000 next edge.
- STRETCH, rst asserted mid-HOLD (cnt=2) -> all blank next edge. After release with no events, channel stays blank (no residual count).

Source files
------------

// File: rtl/status_seg7_pkg.sv
// Shared constants and types for the status 7-segment panel.
package status_seg7_pkg;

  // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK  = '1;
  localparam logic [6:0] SEG_ALL_ON = '0;
  localparam logic [6:0] SEG_0      = 7'b1000000;
  localparam logic [6:0] SEG_1      = 7'b1111001;
  localparam logic [6:0] SEG_2      = 7'b0100100;
  localparam logic [6:0] SEG_3      = 7'b0110000;
  localparam logic [6:0] SEG_4      = 7'b0011001;
  localparam logic [6:0] SEG_5      = 7'b0010010;
  localparam logic [6:0] SEG_6      = 7'b0000010;
  localparam logic [6:0] SEG_7      = 7'b1111000;
  localparam logic [6:0] SEG_8      = 7'b0000000;
  localparam logic [6:0] SEG_9      = 7'b0010000;
  localparam logic [6:0] SEG_S      = 7'b0010010;
  localparam logic [6:0] SEG_E      = 7'b0000110;
  localparam logic [6:0] SEG_U      = 7'b1000001;

  // Display mode encoding; 2'b11 behaves as LIVE.
  localparam logic [1:0] MODE_LIVE    = 2'b00;
  localparam logic [1:0] MODE_STRETCH = 2'b01;
  localparam logic [1:0] MODE_STICKY  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_HOLD,
    ST_LATCHED
  } chan_state_e;

endpackage

// File: rtl/status_seg7_chan.sv
// One status channel: event FSM, hold counter and registered glyph mux.
module status_seg7_chan
  import status_seg7_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 50000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       event_i,
  input  logic [1:0] mode_i,
  input  logic       clear_all_i,
  input  logic       blink_en_i,
  input  logic       lamp_test_i,
  input  logic       phase_i,
  input  logic [6:0] glyph_i,
  output logic [6:0] seg_o,
  output logic       not_idle_o
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);

  chan_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [6:0]       seg_q, seg_d;

  // Next-state and hold counter; event beats clear_all beats mode/counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (event_i) begin
      state_d = ST_ACTIVE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_ACTIVE: begin
          unique case (mode_i)
            MODE_STRETCH: begin
              state_d = ST_HOLD;
              cnt_d   = CNT_RELOAD;
            end
            MODE_STICKY: state_d = ST_LATCHED;
            default:     state_d = ST_IDLE;
          endcase
        end
        ST_HOLD: begin
          if (clear_all_i || (mode_i != MODE_STRETCH) || (cnt_q == '0)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        ST_LATCHED: begin
          if (clear_all_i || (mode_i != MODE_STICKY)) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Digit pattern derived from the next state so it lands with the state.
  always_comb begin
    seg_d = SEG_BLANK;
    if (lamp_test_i) begin
      seg_d = SEG_ALL_ON;
    end else begin
      unique case (state_d)
        ST_ACTIVE, ST_HOLD: seg_d = glyph_i;
        ST_LATCHED:         seg_d = (!blink_en_i || phase_i) ? glyph_i : SEG_BLANK;
        default:            seg_d = SEG_BLANK;
      endcase
    end
  end

  // State, counter and digit registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      seg_q   <= seg_d;
    end
  end

  assign seg_o      = seg_q;
  assign not_idle_o = (state_d != ST_IDLE);

endmodule

// File: rtl/status_seg7_panel.sv
// Status panel top: shared blink prescaler, NUM_CH channels, status_any.
module status_seg7_panel
  import status_seg7_pkg::*;
#(
  parameter int unsigned            NUM_CH      = 3,
  parameter logic [7*NUM_CH-1:0]    GLYPHS      = {SEG_U, SEG_E, SEG_S},
  parameter int unsigned            HOLD_CYCLES = 50000000,
  parameter int unsigned            BLINK_DIV   = 25000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NUM_CH-1:0]     event_in,
  input  logic [1:0]            mode,
  input  logic                  clear_all,
  input  logic                  blink_en,
  input  logic                  lamp_test,
  output logic [7*NUM_CH-1:0]   seg_out,
  output logic                  status_any
);

  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [BW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic [NUM_CH-1:0] not_idle;
  logic              status_any_q;

  // Blink prescaler: count 0..BLINK_DIV-1, toggle phase on wrap.
  always_comb begin
    blink_cnt_d = blink_cnt_q + BW'(1);
    phase_d     = phase_q;
    if (blink_cnt_q == BW'(BLINK_DIV - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  // Prescaler and status_any registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      blink_cnt_q  <= '0;
      phase_q      <= 1'b1;
      status_any_q <= 1'b0;
    end else begin
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      status_any_q <= |not_idle;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
    status_seg7_chan #(
      .HOLD_CYCLES(HOLD_CYCLES)
    ) u_chan (
      .clk_i      (clk),
      .rst_i      (rst),
      .event_i    (event_in[g]),
      .mode_i     (mode),
      .clear_all_i(clear_all),
      .blink_en_i (blink_en),
      .lamp_test_i(lamp_test),
      .phase_i    (phase_d),
      .glyph_i    (GLYPHS[7*g +: 7]),
      .seg_o      (seg_out[7*g +: 7]),
      .not_idle_o (not_idle[g])
    );
  end

  assign status_any = status_any_q;

endmodule

// File: tb/tb_status_seg7_panel.sv
// Self-checking bench for status_seg7_panel with a behavioural model.
module tb_status_seg7_panel;

  localparam int unsigned NCH   = 3;
  localparam int unsigned HOLD  = 4;
  localparam int unsigned BDIV  = 2;
  localparam logic [20:0] GLY   = {7'b1000001, 7'b0000110, 7'b0010010};
  localparam logic [20:0] BLANK3 = '1;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  event_in;
  logic [1:0]  mode;
  logic        clear_all, blink_en, lamp_test;
  logic [20:0] seg_out;
  logic        status_any;

  int compared   = 0;
  int mismatched = 0;

  status_seg7_panel #(
    .NUM_CH     (NCH),
    .GLYPHS     (GLY),
    .HOLD_CYCLES(HOLD),
    .BLINK_DIV  (BDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .event_in  (event_in),
    .mode      (mode),
    .clear_all (clear_all),
    .blink_en  (blink_en),
    .lamp_test (lamp_test),
    .seg_out   (seg_out),
    .status_any(status_any)
  );

  always #5 clk = ~clk;

  // Model: per channel "event seen", visible edges remaining after fall, latched flag.
  bit          m_act [NCH];
  int          m_hold[NCH];
  bit          m_lat [NCH];
  int          m_bcnt  = 0;
  bit          m_phase = 1'b1;
  bit          started = 1'b0;
  logic [20:0] exp_seg = '1;
  logic        exp_any = 1'b0;
  logic [20:0] gly_v   = GLY;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NCH; i++) begin
        m_act[i] = 0; m_hold[i] = 0; m_lat[i] = 0;
      end
      m_bcnt = 0; m_phase = 1;
      exp_seg = '1; exp_any = 0;
    end else begin
      m_bcnt++;
      if (m_bcnt == BDIV) begin m_bcnt = 0; m_phase = !m_phase; end
      exp_any = 0;
      for (int i = 0; i < NCH; i++) begin
        if (event_in[i]) begin
          m_act[i] = 1; m_hold[i] = 0; m_lat[i] = 0;
        end else if (m_act[i]) begin
          m_act[i] = 0;
          if (mode == 2'b01) m_hold[i] = HOLD;
          else if (mode == 2'b10) m_lat[i] = 1;
        end else if (m_hold[i] > 0) begin
          if (clear_all || mode != 2'b01) m_hold[i] = 0;
          else m_hold[i] = m_hold[i] - 1;
        end else if (m_lat[i]) begin
          if (clear_all || mode != 2'b10) m_lat[i] = 0;
        end
        if (lamp_test) exp_seg[7*i +: 7] = 7'b0000000;
        else if (m_act[i] || m_hold[i] > 0) exp_seg[7*i +: 7] = gly_v[7*i +: 7];
        else if (m_lat[i] && (!blink_en || m_phase)) exp_seg[7*i +: 7] = gly_v[7*i +: 7];
        else exp_seg[7*i +: 7] = 7'b1111111;
        if (m_act[i] || m_hold[i] > 0 || m_lat[i]) exp_any = 1;
      end
    end
    started = 1;
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (started) begin
      compared++;
      if (seg_out !== exp_seg || status_any !== exp_any) begin
        mismatched++;
        $display("FAIL cycle_cmp t=%0t seg got %b want %b any got %b want %b",
                 $time, seg_out, exp_seg, status_any, exp_any);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string name, input logic [20:0] got, input logic [20:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got %b want %b", name, got, exp);
    end
  endtask

  int n;

  initial begin
    rst = 1; event_in = 3'b111; mode = 2'b00;
    clear_all = 0; blink_en = 0; lamp_test = 0;
    tick(); tick();
    chk("rst_seg", seg_out, BLANK3);
    chk("rst_any", 21'(status_any), 21'd0);
    rst = 0;
    tick();
    chk("release_glyphs", seg_out, 21'b1000001_0000110_0010010);
    chk("release_any", 21'(status_any), 21'd1);
    event_in = 3'b000;
    tick();
    chk("live_release_off", seg_out, BLANK3);

    // LIVE single-cycle event
    event_in = 3'b001; tick();
    chk("live_d0_on", seg_out, {7'b1111111, 7'b1111111, 7'b0010010});
    event_in = 3'b000; tick();
    chk("live_d0_off", seg_out, BLANK3);

    // STRETCH single pulse: visible k..k+4
    mode = 2'b01;
    event_in = 3'b010; tick();
    chk("str_k", seg_out, {7'b1111111, 7'b0000110, 7'b1111111});
    event_in = 3'b000;
    repeat (4) tick();
    chk("str_k4", seg_out, {7'b1111111, 7'b0000110, 7'b1111111});
    tick();
    chk("str_k5", seg_out, BLANK3);

    // STRETCH re-arm: pulses at k and k+3, visible through k+7
    event_in = 3'b010; tick();
    event_in = 3'b000; tick(); tick();
    event_in = 3'b010; tick();
    event_in = 3'b000;
    repeat (4) tick();
    chk("rearm_k7", seg_out, {7'b1111111, 7'b0000110, 7'b1111111});
    tick();
    chk("rearm_k8", seg_out, BLANK3);

    // mode 11 behaves as LIVE
    mode = 2'b11;
    event_in = 3'b010; tick();
    event_in = 3'b000; tick();
    chk("mode3_live", seg_out, BLANK3);

    // STICKY with blink
    mode = 2'b10; blink_en = 1;
    event_in = 3'b100; tick();
    chk("sticky_active", seg_out, {7'b1000001, 7'b1111111, 7'b1111111});
    event_in = 3'b000;
    n = 0;
    repeat (4) begin
      tick();
      if (seg_out[20:14] == 7'b1000001) n++;
    end
    chk("blink_half", 21'(n), 21'd2);
    chk("sticky_any", 21'(status_any), 21'd1);
    clear_all = 1; tick();
    chk("clear_seg", seg_out, BLANK3);
    chk("clear_any", 21'(status_any), 21'd0);
    clear_all = 0;

    // event beats clear_all, then lamp test
    blink_en = 0;
    event_in = 3'b001; tick();
    event_in = 3'b000; tick();
    chk("latched_d0", seg_out, {7'b1111111, 7'b1111111, 7'b0010010});
    event_in = 3'b001; clear_all = 1; tick();
    chk("event_beats_clear", seg_out, {7'b1111111, 7'b1111111, 7'b0010010});
    chk("event_beats_clear_any", 21'(status_any), 21'd1);
    event_in = 3'b000; clear_all = 0; lamp_test = 1; tick();
    chk("lamp_test", seg_out, 21'd0);
    lamp_test = 0; clear_all = 1; tick();
    clear_all = 0;
    chk("after_lamp_clear", seg_out, BLANK3);

    // reset mid-HOLD leaves no residual count
    mode = 2'b01;
    event_in = 3'b001; tick();
    event_in = 3'b000; tick(); tick();
    rst = 1; tick();
    chk("rst_mid_hold_seg", seg_out, BLANK3);
    chk("rst_mid_hold_any", 21'(status_any), 21'd0);
    rst = 0;
    repeat (6) tick();
    chk("no_residual_seg", seg_out, BLANK3);
    chk("no_residual_any", 21'(status_any), 21'd0);

    repeat (2) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
